// File: rtl/mem_access_unit.sv
// Core-to-RAM load/store unit: one transaction at a time, with alignment checks,
// little-endian lane extraction and sign/zero extension of load results.
module mem_access_unit #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_error,
  output logic [ADDRESS_WIDTH-1:0] Addr,
  output logic [DATA_WIDTH-1:0]    Data,
  output logic                     W_EN,
  output logic [1:0]               sel,
  input  logic [DATA_WIDTH-1:0]    Output_Data
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WRITE     = 2'b01,
    READ_WAIT = 2'b10,
    RESP      = 2'b11
  } state_e;

  localparam int unsigned    CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 size_q, size_d;
  logic                       uns_q, uns_d;
  logic [1:0]                 alo_q, alo_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [1:0]                 sel_q, sel_d;
  logic                       wen_q, wen_d;
  logic                       ready_q, ready_d;
  logic                       rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       rerr_q, rerr_d;

  logic                       req_err_c;
  logic [7:0]                 byte_c;
  logic [15:0]                half_c;
  logic [DATA_WIDTH-1:0]      load_ext_c;

  // Reserved size, odd half address, or word address off a 4-byte boundary.
  assign req_err_c = (req_size == SIZE_RSVD) ||
                     ((req_size == SIZE_HALF) && req_addr[0]) ||
                     ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

  // Lane select and extension of the returned RAM word.
  always_comb begin
    byte_c     = Output_Data[{alo_q, 3'b000} +: 8];
    half_c     = Output_Data[{alo_q[1], 4'b0000} +: 16];
    load_ext_c = Output_Data;
    case (size_q)
      SIZE_BYTE: load_ext_c = {{(DATA_WIDTH-8){~uns_q & byte_c[7]}}, byte_c};
      SIZE_HALF: load_ext_c = {{(DATA_WIDTH-16){~uns_q & half_c[15]}}, half_c};
      default:   load_ext_c = Output_Data;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    uns_d    = uns_q;
    alo_d    = alo_q;
    addr_d   = addr_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          uns_d  = req_unsigned;
          alo_d  = req_addr[1:0];
          if (req_err_c) begin
            state_d = RESP;
            rdata_d = '0;
            rerr_d  = 1'b1;
          end else if (req_we) begin
            state_d = WRITE;
            addr_d  = req_addr;
            data_d  = req_wdata;
            sel_d   = req_size;
          end else begin
            state_d = READ_WAIT;
            addr_d  = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
            sel_d   = SIZE_WORD;
            cnt_d   = '0;
          end
        end
      end
      WRITE: begin
        state_d = RESP;
        rdata_d = '0;
        rerr_d  = 1'b0;
      end
      READ_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          rdata_d = load_ext_c;
          rerr_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wen_d    = (state_d == WRITE);
    ready_d  = (state_d == IDLE);
    rvalid_d = (state_d == RESP);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      alo_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      wen_q    <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      alo_q    <= alo_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      wen_q    <= wen_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_error = rerr_q;
  assign Addr       = addr_q;
  assign Data       = data_q;
  assign W_EN       = wen_q;
  assign sel        = sel_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural RAM with configurable read
// latency plus a word-array reference model of memory and load/store semantics.
module tb_mem_access_unit;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_error;
  logic [AW-1:0] Addr;
  logic [DW-1:0] Data;
  logic          W_EN;
  logic [1:0]    sel;
  logic [DW-1:0] Output_Data;

  int total = 0;
  int bad   = 0;

  logic        mem_init;
  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] pipe    [0:3];
  logic [7:0]  ram_idx;

  always #5 CLK = ~CLK;

  mem_access_unit #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (LAT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .Addr        (Addr),
    .Data        (Data),
    .W_EN        (W_EN),
    .sel         (sel),
    .Output_Data (Output_Data)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // RAM device: byte-lane writes, read data delayed LAT cycles after Addr.
  assign ram_idx = Addr[9:2];
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (W_EN) begin
      case (sel)
        2'b00:   ram[ram_idx] <= Data;
        2'b01:   ram[ram_idx][Addr[1]*16 +: 16] <= Data[15:0];
        2'b10:   ram[ram_idx][Addr[1:0]*8 +: 8] <= Data[7:0];
        default: ;
      endcase
    end
    pipe[0] <= ram[ram_idx];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign Output_Data = (LAT == 1) ? ram[ram_idx] : pipe[LAT-2];

  // One complete transaction against the reference model.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic hold, input logic [31:0] nxt_addr);
    logic        err;
    int          exp_lat, got_lat, wen_cnt, n, sh;
    logic [31:0] exp_rd, w, mask;
    logic [7:0]  b;
    logic [15:0] h;

    err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b00 && addr[1:0] != 2'b00);
    exp_rd = 32'h0;
    if (err) begin
      exp_lat = 1;
    end else if (we) begin
      exp_lat = 2;
      w = ref_mem[addr[9:2]];
      if (size == 2'b00) begin
        w = wd;
      end else begin
        sh   = (size == 2'b01) ? 16 * int'(addr[1]) : 8 * int'(addr[1:0]);
        mask = (size == 2'b01) ? 32'hFFFF : 32'hFF;
        w    = (w & ~(mask << sh)) | ((wd & mask) << sh);
      end
      ref_mem[addr[9:2]] = w;
    end else begin
      exp_lat = LAT + 1;
      w = ref_mem[addr[9:2]];
      if (size == 2'b10) begin
        b = 8'((w >> (8 * int'(addr[1:0]))) & 32'hFF);
        exp_rd = 32'(b);
        if (!uns && b[7]) exp_rd = exp_rd + 32'hFFFFFF00;
      end else if (size == 2'b01) begin
        h = 16'((w >> (16 * int'(addr[1]))) & 32'hFFFF);
        exp_rd = 32'(h);
        if (!uns && h[15]) exp_rd = exp_rd + 32'hFFFF0000;
      end else begin
        exp_rd = w;
      end
    end

    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept addr=%h: req_ready=%b, required 1", addr, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    if (hold) begin
      req_addr = nxt_addr;
    end else begin
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    end

    got_lat = 0; wen_cnt = 0;
    for (int c = 1; c <= 12 && got_lat == 0; c++) begin
      if (c > 1) begin @(posedge CLK); #1; end
      if (W_EN === 1'b1) begin
        wen_cnt++;
        total++;
        if (Addr !== addr || Data !== wd || sel !== size) begin
          bad++;
          $display("FAIL write_bus: Addr=%h Data=%h sel=%b, required %h %h %b",
                   Addr, Data, sel, addr, wd, size);
        end
      end
      total++;
      if (req_ready !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready cyc=%0d: req_ready=%b, required 0", c, req_ready);
      end
      if (resp_valid === 1'b1) got_lat = c;
    end
    total++;
    if (got_lat != exp_lat) begin
      bad++;
      $display("FAIL latency addr=%h: %0d cycles, required %0d", addr, got_lat, exp_lat);
    end
    total++;
    if (resp_error !== err || resp_rdata !== exp_rd) begin
      bad++;
      $display("FAIL resp addr=%h size=%b: err=%b rdata=%h, required err=%b rdata=%h",
               addr, size, resp_error, resp_rdata, err, exp_rd);
    end
    total++;
    if (wen_cnt != ((we && !err) ? 1 : 0)) begin
      bad++;
      $display("FAIL wen_count: %0d, required %0d", wen_cnt, (we && !err) ? 1 : 0);
    end
    if (!we && !err) begin
      total++;
      if (Addr !== {addr[31:2], 2'b00} || sel !== 2'b00) begin
        bad++;
        $display("FAIL load_bus: Addr=%h sel=%b, required %h 00", Addr, sel,
                 {addr[31:2], 2'b00});
      end
    end
    @(posedge CLK); #1;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || W_EN !== 1'b0 ||
        resp_rdata !== exp_rd || resp_error !== err) begin
      bad++;
      $display("FAIL after_resp: valid=%b ready=%b wen=%b rdata=%h err=%b, required 0 1 0 %h %b",
               resp_valid, req_ready, W_EN, resp_rdata, resp_error, exp_rd, err);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; mem_init = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h12345678;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b valid=%b err=%b, required 1 0 0",
               req_ready, resp_valid, resp_error);
    end
    total++;
    if (resp_rdata !== 32'h0 || W_EN !== 1'b0) begin
      bad++;
      $display("FAIL reset_resp: rdata=%h wen=%b, required 0 0", resp_rdata, W_EN);
    end
    total++;
    if (Addr !== 32'h0 || Data !== 32'h0 || sel !== 2'b00) begin
      bad++;
      $display("FAIL reset_bus: Addr=%h Data=%h sel=%b, required 0 0 0", Addr, Data, sel);
    end
    @(negedge CLK);
    req_valid = 1'b0; RST = 1'b0; mem_init = 1'b0;
  endtask

  task automatic test_spec_vectors();
    run_txn(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0);
    run_txn(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    run_txn(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 1'b0, 32'h0);
    run_txn(1'b1, 2'b01, 1'b0, 32'h05, 32'hCAFEF00D, 1'b0, 32'h0);
    run_txn(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    run_txn(1'b1, 2'b11, 1'b0, 32'h24, 32'h11111111, 1'b0, 32'h0);
  endtask

  task automatic test_reset_midflight();
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h24; req_wdata = 32'h0;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
    @(posedge CLK); #1;
    total++;
    if (resp_valid !== 1'b0 || W_EN !== 1'b0 || req_ready !== 1'b1 || Addr !== 32'h0) begin
      bad++;
      $display("FAIL midflight_reset: valid=%b wen=%b ready=%b Addr=%h, required 0 0 1 0",
               resp_valid, W_EN, req_ready, Addr);
    end
    @(negedge CLK);
    RST = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || W_EN !== 1'b0) begin
        bad++;
        $display("FAIL aborted_txn cyc=%0d: valid=%b ready=%b wen=%b, required 0 1 0",
                 c, resp_valid, req_ready, W_EN);
      end
    end
    run_txn(1'b0, 2'b00, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 2'b00, 1'b0, 32'h00, 32'h0, 1'b1, 32'h04);
    run_txn(1'b0, 2'b00, 1'b0, 32'h04, 32'h0, 1'b1, 32'h08);
    run_txn(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [1:0] sz;
    for (int i = 0; i < 60; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_txn(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 1023)),
              $urandom, 1'b0, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_spec_vectors();
    test_misaligned();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning width of request and memory address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning width of the data path (only 32 supported).
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal 1..4, meaning cycles from memory address presentation to valid mem_rdata.
REQ-004 SHALL have port CLK  input  1  rising-edge clock.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high; the block uses one clock, CLK.
REQ-006 SHALL have port req_valid  input  1  core request present.
REQ-007 SHALL have port req_ready  output  1  unit can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  00 word, 01 half, 10 byte, 11 reserved.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_addr  input  ADDRESS_WIDTH  byte address.
REQ-012 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-013 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-014 SHALL have port resp_rdata  output  DATA_WIDTH  extended load result.
REQ-015 SHALL have port resp_error  output  1  misaligned or reserved-size request, qualified by resp_valid.
REQ-016 SHALL have ports Addr output ADDRESS_WIDTH, Data output DATA_WIDTH, W_EN output 1, sel output 2, Output_Data input DATA_WIDTH, connecting to the RAM.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ_WAIT, RESP.
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-019 SHALL register req_* fields on acceptance; later req_* changes SHALL NOT affect the transaction in flight.
REQ-020 SHALL flag an error when req_size = 11, half access with addr[0] = 1, or word access with addr[1:0] != 00.
REQ-021 On an erroneous request: IDLE -> RESP; resp_error = 1, resp_rdata = 0, W_EN never asserted.
REQ-022 On a valid store: IDLE -> WRITE (one cycle: Addr = req_addr, Data = req_wdata, sel = req_size, W_EN = 1) -> RESP.
REQ-023 On a valid load: IDLE -> READ_WAIT; Addr = {req_addr[ADDRESS_WIDTH-1:2], 2'b00}, sel = 00, W_EN = 0; a latency counter SHALL capture Output_Data on the READ_LATENCY-th rising edge after entering READ_WAIT, then go to RESP.
REQ-024 Load lane extraction is little-endian: byte = word[8*addr[1:0] +: 8], half = word[16*addr[1] +: 16].
REQ-025 Byte and half results SHALL be sign-extended from bit 7 or 15 unless req_unsigned = 1; word loads SHALL ignore req_unsigned.
REQ-026 In RESP, resp_valid = 1 for exactly one cycle, then IDLE; there is no response back-pressure.
REQ-027 Latency from accept edge to resp_valid cycle: error 1 cycle, store 2 cycles, load READ_LATENCY + 1 cycles.
REQ-028 W_EN SHALL be 1 only in WRITE; Addr, Data, and sel SHALL hold their last values in all other states.
REQ-029 resp_rdata and resp_error SHALL hold until the next RESP; resp_rdata SHALL be 0 after a store.
REQ-030 A request presented while req_ready = 0 SHALL be ignored until IDLE; back-to-back requests issue one transaction per RESP -> IDLE cycle.

Reset
REQ-031 RST = 1 on a rising edge SHALL force IDLE and set req_ready = 1, resp_valid = 0, resp_error = 0, resp_rdata = 0, W_EN = 0, Addr = 0, Data = 0, sel = 0, counter = 0.
REQ-032 RST asserted mid-transaction SHALL abort it, with no resp_valid and W_EN = 0 from the next cycle; RST SHALL override req_valid in the same cycle.

Verification
REQ-033 Store word: addr 0x10, wdata 0xDEADBEEF, size 00 -> W_EN = 1 for one cycle with Addr 0x10 and Data 0xDEADBEEF; resp_valid 2 cycles after accept; resp_error = 0.
REQ-034 Load byte signed: RAM word at 0x10 = 0xDEADBEEF, addr 0x13, size 10, unsigned 0 -> Addr 0x10, resp_rdata 0xFFFFFFDE; with unsigned 1 -> 0x000000DE.
REQ-035 Load half: addr 0x12, size 01, unsigned 0 -> 0xFFFFDEAD; addr 0x10 -> 0xFFFFBEEF; READ_LATENCY = 3 -> resp_valid 4 cycles after accept.
REQ-036 Misaligned: word load at 0x06, half store at 0x05, and size 11 -> resp_valid 1 cycle after accept, resp_error = 1, W_EN stays 0.
REQ-037 Reset in READ_WAIT with READ_LATENCY = 2 -> no resp_valid; req_ready = 1 the cycle after reset; a following load completes normally.
REQ-038 req_valid held high for three loads (0x00, 0x04, 0x08) -> three resp_valid pulses, each with the matching RAM word, and req_ready low between accepts.
